// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe cell, turn and controller state encodings
package ttt_pkg;
  localparam int NUM_CELLS = 9;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1 = 2'b01;
  localparam logic [1:0] CELL_P2 = 2'b10;
  localparam logic TURN_P1 = 1'b0;
  localparam logic TURN_P2 = 1'b1;
  localparam logic [2:0] ST_WAIT = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_COMMIT = 3'd2;
  localparam logic [2:0] ST_ILLEGAL = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  typedef enum logic [2:0] {
    S_WAIT = ST_WAIT,
    S_CHECK = ST_CHECK,
    S_COMMIT = ST_COMMIT,
    S_ILLEGAL = ST_ILLEGAL,
    S_DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/move_ctrl_if.sv
// move_ctrl_if: request/board inputs and move/status outputs of the turn controller
interface move_ctrl_if;
  import ttt_pkg::*;
  logic req_valid;
  logic [NUM_CELLS-1:0] req_sel;
  logic [2*NUM_CELLS-1:0] board;
  logic game_over;
  logic [NUM_CELLS-1:0] P1_en;
  logic [NUM_CELLS-1:0] P2_en;
  logic ill_move;
  logic turn;
  logic [3:0] move_cnt;
  logic done;
  logic timeout;
  modport master (
    output req_valid, req_sel, board, game_over,
    input P1_en, P2_en, ill_move, turn, move_cnt, done, timeout
  );
  modport slave (
    input req_valid, req_sel, board, game_over,
    output P1_en, P2_en, ill_move, turn, move_cnt, done, timeout
  );
endinterface

// File: rtl/move_timer.sv
// move_timer: idle down-counter, reloaded while not running, pulses o_expire on reaching zero
module move_timer #(
  parameter int CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_expire
);
  localparam int W = $clog2(CYC + 1);
  localparam logic [W-1:0] LOAD = W'(CYC - 1);
  logic [W-1:0] r_cnt;
  assign o_expire = i_run && (r_cnt == '0);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cnt <= LOAD;
    else r_cnt <= (!i_run || o_expire) ? LOAD : r_cnt - W'(1);
  end
endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: turn/legality controller issuing one-cycle P1/P2 write enables or ill_move.
// Optional idle-turn forfeit enabled with `define MOVE_CTRL_TIMEOUT_EN.
module move_ctrl
  import ttt_pkg::*;
#(
  parameter int ILL_HOLD_CYC = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic clk,
  input logic reset_n,
  move_ctrl_if.slave bus
);
  localparam int HW = $clog2(ILL_HOLD_CYC + 1);
  state_t r_state;
  logic [NUM_CELLS-1:0] r_req, r_p1_en, r_p2_en, w_full;
  logic [HW-1:0] r_hold;
  logic [3:0] r_cnt;
  logic r_ill, r_turn, r_done, r_timeout, w_legal, w_expire;
  always_comb begin
    w_full = '0;
    for (int k = 0; k < NUM_CELLS; k++) w_full[k] = bus.board[2*k +: 2] != CELL_EMPTY;
  end
  assign w_legal = $onehot(r_req) && !(|(r_req & w_full));
`ifdef MOVE_CTRL_TIMEOUT_EN
  move_timer #(.CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .i_run(r_state == S_WAIT),
    .o_expire(w_expire)
  );
`else
  logic w_unused;
  assign w_unused = |TIMEOUT_CYC;
  assign w_expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_req <= '0;
      r_p1_en <= '0;
      r_p2_en <= '0;
      r_hold <= '0;
      r_cnt <= '0;
      r_ill <= 1'b0;
      r_turn <= TURN_P1;
      r_done <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_p1_en <= '0;
      r_p2_en <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_WAIT:
          if (bus.game_over) begin
            r_state <= S_DONE;
            r_done <= 1'b1;
          end else if (bus.req_valid) begin
            r_req <= bus.req_sel;
            r_state <= S_CHECK;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_turn <= ~r_turn;
          end
        S_CHECK:
          if (bus.game_over) begin
            r_state <= S_DONE;
            r_done <= 1'b1;
          end else if (w_legal) begin
            r_state <= S_COMMIT;
            if (r_turn == TURN_P1) r_p1_en <= r_req;
            else r_p2_en <= r_req;
          end else begin
            r_state <= S_ILLEGAL;
            r_ill <= 1'b1;
            r_hold <= HW'(ILL_HOLD_CYC - 1);
          end
        S_COMMIT: begin
          r_turn <= ~r_turn;
          r_cnt <= r_cnt + 4'd1;
          r_state <= (r_cnt == 4'd8) ? S_DONE : S_WAIT;
          r_done <= (r_cnt == 4'd8);
        end
        S_ILLEGAL:
          if (bus.game_over) begin
            r_ill <= 1'b0;
            r_state <= S_DONE;
            r_done <= 1'b1;
          end else if (r_hold == '0) begin
            r_ill <= 1'b0;
            r_state <= S_WAIT;
          end else r_hold <= r_hold - HW'(1);
        default: begin
          r_state <= S_DONE;
          r_done <= 1'b1;
        end
      endcase
    end
  end
  assign bus.P1_en = r_p1_en;
  assign bus.P2_en = r_p2_en;
  assign bus.ill_move = r_ill;
  assign bus.turn = r_turn;
  assign bus.move_cnt = r_cnt;
  assign bus.done = r_done;
  assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: directed self-checking bench for move_ctrl
module tb_move_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int n_cmp = 0;
  int n_bad = 0;
  move_ctrl_if bus();
  move_ctrl #(.ILL_HOLD_CYC(4), .TIMEOUT_CYC(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [25:0] outs();
    return {bus.P1_en, bus.P2_en, bus.ill_move, bus.turn, bus.move_cnt, bus.done, bus.timeout};
  endfunction

  // advance one posedge, land on the negedge, and let the board registers absorb enables
  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (bus.P1_en[k]) bus.board[2*k +: 2] = 2'b01;
      if (bus.P2_en[k]) bus.board[2*k +: 2] = 2'b10;
    end
  endtask

  task automatic pulse(input logic [8:0] sel);
    bus.req_valid = 1'b1;
    bus.req_sel = sel;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel = '0;
    bus.board = '0;
    bus.game_over = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel = '0;
    bus.board = '0;
    bus.game_over = 1'b0;
    cyc();
    n_cmp++;
    if (outs() !== 26'h0) begin n_bad++; $display("FAIL reset_outs got=%h exp=%h", outs(), 26'h0); end
    reset_n = 1'b1;
    cyc();
    n_cmp++;
    if (outs() !== 26'h0) begin n_bad++; $display("FAIL reset_idle got=%h exp=%h", outs(), 26'h0); end
  endtask

  task automatic test_legal();
    pulse(9'h001);
    n_cmp++;
    if (bus.P1_en !== 9'h000) begin n_bad++; $display("FAIL legal_n1_p1 got=%h exp=%h", bus.P1_en, 9'h000); end
    cyc();
    n_cmp++;
    if (bus.P1_en !== 9'h001) begin n_bad++; $display("FAIL legal_n2_p1 got=%h exp=%h", bus.P1_en, 9'h001); end
    n_cmp++;
    if ({bus.P2_en, bus.ill_move} !== 10'h0) begin n_bad++; $display("FAIL legal_n2_other got=%h exp=0", {bus.P2_en, bus.ill_move}); end
    cyc();
    n_cmp++;
    if ({bus.P1_en, bus.turn, bus.move_cnt} !== {9'h000, 1'b1, 4'd1}) begin
      n_bad++; $display("FAIL legal_after got=%h/%b/%0d exp=000/1/1", bus.P1_en, bus.turn, bus.move_cnt);
    end
  endtask

  task automatic test_illegal();
    bus.board[9:8] = 2'b01;
    pulse(9'h010);
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_cmp++;
      if (bus.ill_move !== (i < 4)) begin n_bad++; $display("FAIL occ_ill[%0d] got=%b exp=%b", i, bus.ill_move, i < 4); end
      n_cmp++;
      if ({bus.P1_en, bus.P2_en} !== 18'h0) begin n_bad++; $display("FAIL occ_en[%0d] got=%h exp=0", i, {bus.P1_en, bus.P2_en}); end
    end
    n_cmp++;
    if ({bus.turn, bus.move_cnt} !== {1'b1, 4'd1}) begin
      n_bad++; $display("FAIL occ_state got=%b/%0d exp=1/1", bus.turn, bus.move_cnt);
    end
  endtask

  task automatic test_multihot();
    logic [8:0] sels [2];
    sels[0] = 9'h003;
    sels[1] = 9'h000;
    for (int j = 0; j < 2; j++) begin
      pulse(sels[j]);
      for (int i = 0; i < 5; i++) begin
        cyc();
        n_cmp++;
        if (bus.ill_move !== (i < 4)) begin n_bad++; $display("FAIL hot_ill[%h][%0d] got=%b exp=%b", sels[j], i, bus.ill_move, i < 4); end
        n_cmp++;
        if ({bus.P1_en, bus.P2_en} !== 18'h0) begin n_bad++; $display("FAIL hot_en[%h][%0d] got=%h exp=0", sels[j], i, {bus.P1_en, bus.P2_en}); end
      end
      n_cmp++;
      if ({bus.turn, bus.move_cnt} !== {1'b1, 4'd1}) begin
        n_bad++; $display("FAIL hot_state[%h] got=%b/%0d exp=1/1", sels[j], bus.turn, bus.move_cnt);
      end
    end
  endtask

  task automatic test_nine();
    logic [8:0] sel;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      sel = 9'h001 << k;
      bus.req_valid = 1'b1;
      bus.req_sel = sel;
      cyc();
      if (k == 0) bus.req_sel = 9'h100;
      else bus.req_valid = 1'b0;
      cyc();
      bus.req_valid = 1'b0;
      n_cmp++;
      if ({bus.P1_en, bus.P2_en} !== ((k % 2 == 0) ? {sel, 9'h000} : {9'h000, sel})) begin
        n_bad++; $display("FAIL nine_en[%0d] got=%h/%h exp_sel=%h", k, bus.P1_en, bus.P2_en, sel);
      end
      cyc();
      n_cmp++;
      if ({bus.move_cnt, bus.turn, bus.done} !== {4'(k + 1), 1'((k + 1) % 2), k == 8}) begin
        n_bad++; $display("FAIL nine_state[%0d] got=%0d/%b/%b exp=%0d/%0d/%b", k, bus.move_cnt, bus.turn, bus.done, k + 1, (k + 1) % 2, k == 8);
      end
      if (k == 0) begin
        cyc();
        n_cmp++;
        if ({bus.P1_en, bus.P2_en, bus.move_cnt} !== {18'h0, 4'd1}) begin
          n_bad++; $display("FAIL drop_no_queue got=%h/%h/%0d exp=0/0/1", bus.P1_en, bus.P2_en, bus.move_cnt);
        end
      end
    end
    pulse(9'h100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if ({bus.P1_en, bus.P2_en, bus.ill_move, bus.done, bus.move_cnt} !== {18'h0, 1'b0, 1'b1, 4'd9}) begin
        n_bad++; $display("FAIL done_ignore[%0d] got=%h/%h/%b/%b/%0d exp=0/0/0/1/9", i, bus.P1_en, bus.P2_en, bus.ill_move, bus.done, bus.move_cnt);
      end
    end
  endtask

  task automatic test_game_over();
    do_reset();
    pulse(9'h010);
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    n_cmp++;
    if ({bus.P1_en, bus.P2_en, bus.done, bus.move_cnt} !== {18'h0, 1'b1, 4'd0}) begin
      n_bad++; $display("FAIL go_check got=%h/%h/%b/%0d exp=0/0/1/0", bus.P1_en, bus.P2_en, bus.done, bus.move_cnt);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({bus.P1_en, bus.P2_en, bus.done} !== {18'h0, 1'b1}) begin
      n_bad++; $display("FAIL go_stuck got=%h/%h/%b exp=0/0/1", bus.P1_en, bus.P2_en, bus.done);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 26'h0) begin n_bad++; $display("FAIL go_async_reset got=%h exp=%h", outs(), 26'h0); end
    cyc();
    reset_n = 1'b1;
    pulse(9'h100);
    cyc();
    n_cmp++;
    if (bus.P1_en !== 9'h100) begin n_bad++; $display("FAIL midcommit_en got=%h exp=%h", bus.P1_en, 9'h100); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 26'h0) begin n_bad++; $display("FAIL midcommit_abort got=%h exp=%h", outs(), 26'h0); end
    cyc();
    reset_n = 1'b1;
    bus.game_over = 1'b1;
    cyc();
    bus.game_over = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b1) begin n_bad++; $display("FAIL go_wait got=%b exp=1", bus.done); end
  endtask

  task automatic test_timeout();
    do_reset();
`ifdef MOVE_CTRL_TIMEOUT_EN
    for (int i = 1; i <= 9; i++) begin
      cyc();
      n_cmp++;
      if (bus.timeout !== (i == 8)) begin n_bad++; $display("FAIL to_pulse[%0d] got=%b exp=%b", i, bus.timeout, i == 8); end
      if (i >= 8) begin
        n_cmp++;
        if ({bus.turn, bus.move_cnt} !== {1'b1, 4'd0}) begin
          n_bad++; $display("FAIL to_turn[%0d] got=%b/%0d exp=1/0", i, bus.turn, bus.move_cnt);
        end
      end
    end
    for (int i = 10; i <= 15; i++) begin
      cyc();
      n_cmp++;
      if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL to_quiet[%0d] got=%b exp=0", i, bus.timeout); end
    end
    pulse(9'h001);
    n_cmp++;
    if ({bus.timeout, bus.turn} !== 2'b01) begin
      n_bad++; $display("FAIL to_req_wins got=%b/%b exp=0/1", bus.timeout, bus.turn);
    end
    cyc();
    n_cmp++;
    if (bus.P2_en !== 9'h001) begin n_bad++; $display("FAIL to_commit got=%h exp=%h", bus.P2_en, 9'h001); end
`else
    repeat (12) cyc();
    n_cmp++;
    if ({bus.timeout, bus.turn} !== 2'b00) begin
      n_bad++; $display("FAIL to_disabled got=%b/%b exp=0/0", bus.timeout, bus.turn);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_multihot();
    test_nine();
    test_game_over();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
